reg_xfer_engine: RTL and testbench

Parametrised successor to the CPU register-file/source-mux datapath. It owns an N-entry register bank and executes queued register-transfer commands: 8-bit or 16-bit pair loads from a register, an immediate, external memory (req/ack handshake) or the testbench port. A small sequencer serialises pair writes and memory fetches through the bank's single write port. It sits between the decoder (command source) and the memory bus.

---
 rtl/xfer_pkg.sv | 23 ++
 rtl/reg_bank_mp.sv | 38 +++
 rtl/reg_xfer_engine.sv | 163 ++++++++++++++++
 tb/tb_reg_xfer_engine.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xfer_pkg.sv
// Shared constants, sequencer state encoding and index helpers for the
// register-transfer engine.
package xfer_pkg;

  localparam logic [1:0] SRC_REG  = 2'b00;
  localparam logic [1:0] SRC_IMM  = 2'b01;
  localparam logic [1:0] SRC_MEM  = 2'b10;
  localparam logic [1:0] SRC_TEST = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MEM_LO = 3'd1,
    ST_MEM_HI = 3'd2,
    ST_WR_LO  = 3'd3,
    ST_WR_HI  = 3'd4
  } state_e;

  // Base (even) register of the pair that contains idx.
  function automatic logic [31:0] pair_base(input logic [31:0] idx);
    return idx & ~32'd1;
  endfunction

endpackage

// File: rtl/reg_bank_mp.sv
// Register bank: one synchronous write port, three combinational read ports
// (source high, source low, debug), asynchronous clear.
module reg_bank_mp #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_hi_i,
  output logic [DATA_W-1:0] rdata_hi_o,
  input  logic [ADDR_W-1:0] raddr_lo_i,
  output logic [DATA_W-1:0] rdata_lo_o,
  input  logic [ADDR_W-1:0] raddr_dbg_i,
  output logic [DATA_W-1:0] rdata_dbg_o
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  // NOTE: the bank is built from flops, so clearing it on reset is cheap and
  // required; a RAM-style array would not be reset. Sequential state always
  // uses non-blocking assignment so readers in the same edge see old values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_hi_o  = regs_q[raddr_hi_i];
  assign rdata_lo_o  = regs_q[raddr_lo_i];
  assign rdata_dbg_o = regs_q[raddr_dbg_i];

endmodule

// File: rtl/reg_xfer_engine.sv
// Register-transfer engine: accepts one command at a time and serialises its
// byte writes (and memory fetches) through the bank's single write port.
module reg_xfer_engine
  import xfer_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int MEM_AW   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_src,
  input  logic                cmd_pair,
  input  logic [ADDR_W-1:0]   cmd_dst,
  input  logic [ADDR_W-1:0]   cmd_sreg,
  input  logic [2*DATA_W-1:0] cmd_imm,
  input  logic [MEM_AW-1:0]   cmd_maddr,
  output logic                mem_req,
  output logic [MEM_AW-1:0]   mem_addr,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic [2*DATA_W-1:0] test_data,
  output logic                done,
  output logic                busy,
  input  logic [ADDR_W-1:0]   dbg_addr,
  output logic [DATA_W-1:0]   dbg_data
);

  if (NUM_REGS < 2 || (NUM_REGS % 2) != 0) begin : g_bad_num_regs
    $error("reg_xfer_engine: NUM_REGS must be even and at least 2");
  end

  state_e              state_q, state_d;
  logic [2*DATA_W-1:0] buf_q, buf_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic                pair_q, pair_d;
  logic [MEM_AW-1:0]   maddr_q, maddr_d;

  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic [DATA_W-1:0]   wdata;
  logic [ADDR_W-1:0]   sreg_base, dst_base, raddr_hi, raddr_lo;
  logic [DATA_W-1:0]   src_hi, src_lo;

  assign sreg_base = ADDR_W'(pair_base(32'(cmd_sreg)));
  assign dst_base  = ADDR_W'(pair_base(32'(cmd_dst)));
  assign raddr_hi  = sreg_base;
  assign raddr_lo  = cmd_pair ? (sreg_base | ADDR_W'(1)) : cmd_sreg;

  reg_bank_mp #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W)
  ) u_bank (
    .clk        (clk),
    .rst_n      (rst),
    .we_i       (we),
    .waddr_i    (waddr),
    .wdata_i    (wdata),
    .raddr_hi_i (raddr_hi),
    .rdata_hi_o (src_hi),
    .raddr_lo_i (raddr_lo),
    .rdata_lo_o (src_lo),
    .raddr_dbg_i(dbg_addr),
    .rdata_dbg_o(dbg_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
      dst_q   <= '0;
      pair_q  <= 1'b0;
      maddr_q <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      dst_q   <= dst_d;
      pair_q  <= pair_d;
      maddr_q <= maddr_d;
    end
  end

  // NOTE: every signal driven here gets a default first so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    dst_d     = dst_q;
    pair_d    = pair_q;
    maddr_d   = maddr_q;
    cmd_ready = 1'b0;
    mem_req   = 1'b0;
    mem_addr  = '0;
    done      = 1'b0;
    we        = 1'b0;
    waddr     = dst_q;
    wdata     = buf_q[DATA_W-1:0];

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          pair_d  = cmd_pair;
          dst_d   = cmd_pair ? dst_base : cmd_dst;
          maddr_d = cmd_maddr;
          // Operand is captured at accept so overlapping copies are atomic.
          unique case (cmd_src)
            SRC_REG:  buf_d = cmd_pair ? {src_hi, src_lo}
                                       : {{DATA_W{1'b0}}, src_lo};
            SRC_IMM:  buf_d = cmd_pair ? cmd_imm
                                       : {{DATA_W{1'b0}}, cmd_imm[DATA_W-1:0]};
            SRC_TEST: buf_d = cmd_pair ? test_data
                                       : {{DATA_W{1'b0}}, test_data[DATA_W-1:0]};
            default:  buf_d = '0;
          endcase
          state_d = (cmd_src == SRC_MEM) ? ST_MEM_LO : ST_WR_LO;
        end
      end
      ST_MEM_LO: begin
        mem_req  = 1'b1;
        mem_addr = maddr_q;
        if (mem_ack) begin
          buf_d[DATA_W-1:0] = mem_rdata;
          state_d = pair_q ? ST_MEM_HI : ST_WR_LO;
        end
      end
      ST_MEM_HI: begin
        mem_req  = 1'b1;
        mem_addr = maddr_q + MEM_AW'(1);
        if (mem_ack) begin
          buf_d[2*DATA_W-1:DATA_W] = mem_rdata;
          state_d = ST_WR_LO;
        end
      end
      ST_WR_LO: begin
        we    = 1'b1;
        waddr = pair_q ? (dst_q | ADDR_W'(1)) : dst_q;
        wdata = buf_q[DATA_W-1:0];
        if (pair_q) begin
          state_d = ST_WR_HI;
        end else begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WR_HI: begin
        we      = 1'b1;
        waddr   = dst_q;
        wdata   = buf_q[2*DATA_W-1:DATA_W];
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_reg_xfer_engine.sv
// Directed bench for reg_xfer_engine: hand-computed expectations per scenario.
module tb_reg_xfer_engine;

  localparam int DW  = 8;
  localparam int NR  = 8;
  localparam int AW  = 3;
  localparam int MAW = 16;

  localparam logic [1:0] S_REG  = 2'b00;
  localparam logic [1:0] S_IMM  = 2'b01;
  localparam logic [1:0] S_MEM  = 2'b10;
  localparam logic [1:0] S_TEST = 2'b11;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [1:0]      cmd_src = '0;
  logic            cmd_pair = 1'b0;
  logic [AW-1:0]   cmd_dst = '0;
  logic [AW-1:0]   cmd_sreg = '0;
  logic [2*DW-1:0] cmd_imm = '0;
  logic [MAW-1:0]  cmd_maddr = '0;
  logic            mem_req;
  logic [MAW-1:0]  mem_addr;
  logic            mem_ack = 1'b0;
  logic [DW-1:0]   mem_rdata = '0;
  logic [2*DW-1:0] test_data = '0;
  logic            done;
  logic            busy;
  logic [AW-1:0]   dbg_addr = '0;
  logic [DW-1:0]   dbg_data;

  int errors = 0;
  int checks = 0;

  reg_xfer_engine #(
    .DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .MEM_AW(MAW)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_pair(cmd_pair), .cmd_dst(cmd_dst),
    .cmd_sreg(cmd_sreg), .cmd_imm(cmd_imm), .cmd_maddr(cmd_maddr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .test_data(test_data),
    .done(done), .busy(busy),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #10 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int a, output logic [DW-1:0] d);
    dbg_addr = AW'(a);
    #1;
    d = dbg_data;
  endtask

  task automatic count_nonzero(output int n);
    logic [DW-1:0] d;
    n = 0;
    for (int i = 0; i < NR; i++) begin
      rd(i, d);
      if (d !== '0) n++;
    end
  endtask

  task automatic set_cmd(input logic [1:0] src, input logic pair, input int dst,
                         input int sreg, input logic [15:0] imm, input logic [15:0] maddr);
    cmd_src = src; cmd_pair = pair; cmd_dst = AW'(dst); cmd_sreg = AW'(sreg);
    cmd_imm = imm; cmd_maddr = maddr;
  endtask

  task automatic run_cmd(input logic [1:0] src, input logic pair, input int dst,
                         input int sreg, input logic [15:0] imm);
    int n;
    set_cmd(src, pair, dst, sreg, imm, 16'h0000);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (busy && n < 20) begin tick(); n++; end
    checks++;
    if (busy !== 1'b0) begin
      $display("FAIL run_cmd_timeout busy=%b required 0", busy); errors++;
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b0;
    tick(); tick();
    checks++;
    if ({busy, cmd_ready, mem_req, done} !== 4'b0100) begin
      $display("FAIL reset_flags busy/ready/req/done=%b required 0100",
               {busy, cmd_ready, mem_req, done}); errors++;
    end
    checks++;
    if (mem_addr !== 16'h0000) begin
      $display("FAIL reset_mem_addr got=%h required 0000", mem_addr); errors++;
    end
    count_nonzero(n);
    checks++;
    if (n !== 0) begin
      $display("FAIL reset_regs nonzero=%0d required 0", n); errors++;
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_imm();
    logic [DW-1:0] d;
    set_cmd(S_IMM, 1'b0, 3, 0, 16'h00A5, 16'h0000);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    checks++;
    if ({busy, cmd_ready, done} !== 3'b101) begin
      $display("FAIL single_wr_cycle busy/ready/done=%b required 101",
               {busy, cmd_ready, done}); errors++;
    end
    rd(3, d);
    checks++;
    if (d !== 8'h00) begin $display("FAIL single_before_write got=%h required 00", d); errors++; end
    tick();
    checks++;
    if ({busy, done} !== 2'b00) begin
      $display("FAIL single_after busy/done=%b required 00", {busy, done}); errors++;
    end
    rd(3, d);
    checks++;
    if (d !== 8'hA5) begin $display("FAIL single_reg3 got=%h required a5", d); errors++; end
  endtask

  task automatic test_pair_test();
    logic [DW-1:0] d4, d5;
    test_data = 16'h1234;
    set_cmd(S_TEST, 1'b1, 5, 0, 16'h0000, 16'h0000);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    rd(5, d5);
    checks++;
    if ({cmd_ready, done, d5} !== {2'b00, 8'h00}) begin
      $display("FAIL pair_test_c1 ready/done/reg5=%b/%b/%h required 0/0/00", cmd_ready, done, d5); errors++;
    end
    tick();
    rd(5, d5); rd(4, d4);
    checks++;
    if ({cmd_ready, done, d5, d4} !== {2'b01, 8'h34, 8'h00}) begin
      $display("FAIL pair_test_c2 ready/done/reg5/reg4=%b/%b/%h/%h required 0/1/34/00",
               cmd_ready, done, d5, d4); errors++;
    end
    tick();
    rd(5, d5); rd(4, d4);
    checks++;
    if ({cmd_ready, done, d4, d5} !== {2'b10, 8'h12, 8'h34}) begin
      $display("FAIL pair_test_c3 ready/done/reg4/reg5=%b/%b/%h/%h required 1/0/12/34",
               cmd_ready, done, d4, d5); errors++;
    end
  endtask

  task automatic test_pair_mem();
    logic [DW-1:0] d;
    set_cmd(S_MEM, 1'b1, 7, 0, 16'h0000, 16'hFFFF);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({mem_req, mem_addr} !== {1'b1, 16'hFFFF}) begin
        $display("FAIL mem_lo_cycle%0d req/addr=%b/%h required 1/ffff", i, mem_req, mem_addr); errors++;
      end
      if (i == 2) begin mem_ack = 1'b1; mem_rdata = 8'h7E; end
      tick();
      mem_ack = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({mem_req, mem_addr} !== {1'b1, 16'h0000}) begin
        $display("FAIL mem_hi_cycle%0d req/addr=%b/%h required 1/0000", i, mem_req, mem_addr); errors++;
      end
      if (i == 2) begin mem_ack = 1'b1; mem_rdata = 8'h81; end
      tick();
      mem_ack = 1'b0;
    end
    checks++;
    if ({mem_req, done, busy} !== 3'b001) begin
      $display("FAIL mem_wr_lo req/done/busy=%b required 001", {mem_req, done, busy}); errors++;
    end
    tick();
    rd(7, d);
    checks++;
    if ({done, d} !== {1'b1, 8'h7E}) begin
      $display("FAIL mem_reg7 done/reg7=%b/%h required 1/7e", done, d); errors++;
    end
    tick();
    rd(6, d);
    checks++;
    if ({busy, d} !== {1'b0, 8'h81}) begin
      $display("FAIL mem_reg6 busy/reg6=%b/%h required 0/81", busy, d); errors++;
    end
  endtask

  task automatic test_overlap_copy();
    logic [DW-1:0] d [6];
    run_cmd(S_IMM, 1'b1, 0, 0, 16'hAABB);
    run_cmd(S_IMM, 1'b1, 2, 0, 16'hCCDD);
    run_cmd(S_REG, 1'b1, 2, 0, 16'h0000);
    run_cmd(S_REG, 1'b1, 0, 2, 16'h0000);
    run_cmd(S_REG, 1'b1, 5, 1, 16'h0000);
    for (int i = 0; i < 6; i++) rd(i, d[i]);
    checks++;
    if ({d[0], d[1], d[2], d[3]} !== 32'hAABB_AABB) begin
      $display("FAIL overlap_copy regs0..3=%h%h%h%h required aabbaabb", d[0], d[1], d[2], d[3]); errors++;
    end
    checks++;
    if ({d[4], d[5]} !== 16'hAABB) begin
      $display("FAIL odd_index_copy regs4..5=%h%h required aabb", d[4], d[5]); errors++;
    end
  endtask

  task automatic test_reset_mid_mem();
    int n;
    logic done_seen, busy_seen;
    set_cmd(S_MEM, 1'b0, 1, 0, 16'h0000, 16'h1000);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 16'h1000}) begin
      $display("FAIL midreset_pre req/addr=%b/%h required 1/1000", mem_req, mem_addr); errors++;
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({mem_req, busy, mem_addr} !== {2'b00, 16'h0000}) begin
      $display("FAIL midreset_drop req/busy/addr=%b/%b/%h required 0/0/0000", mem_req, busy, mem_addr); errors++;
    end
    count_nonzero(n);
    checks++;
    if (n !== 0) begin $display("FAIL midreset_clear nonzero=%0d required 0", n); errors++; end
    rst = 1'b1;
    done_seen = 1'b0;
    busy_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_ack = 1'b1; mem_rdata = 8'h55;
      tick();
      done_seen |= done;
      busy_seen |= busy;
    end
    mem_ack = 1'b0;
    tick();
    checks++;
    if ({done_seen, busy_seen} !== 2'b00) begin
      $display("FAIL late_ack done/busy seen=%b required 00", {done_seen, busy_seen}); errors++;
    end
    count_nonzero(n);
    checks++;
    if (n !== 0) begin $display("FAIL late_ack_regs nonzero=%0d required 0", n); errors++; end
  endtask

  task automatic test_back_to_back();
    int dsts [4] = '{4, 5, 1, 6};
    int srcs [4] = '{1, 4, 0, 5};
    logic [DW-1:0] exp_r [8] = '{8'h11, 8'h11, 8'h33, 8'h44, 8'h22, 8'h22, 8'h22, 8'h00};
    int acc_cyc [4] = '{0, 0, 0, 0};
    int idx, dones, bad_gap, bad_regs;
    logic rdy;
    logic [DW-1:0] d;
    run_cmd(S_IMM, 1'b0, 0, 0, 16'h0011);
    run_cmd(S_IMM, 1'b0, 1, 0, 16'h0022);
    run_cmd(S_IMM, 1'b0, 2, 0, 16'h0033);
    run_cmd(S_IMM, 1'b0, 3, 0, 16'h0044);
    idx = 0; dones = 0;
    set_cmd(S_REG, 1'b0, dsts[0], srcs[0], 16'h0000, 16'h0000);
    cmd_valid = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      rdy = cmd_ready;
      tick();
      if (done === 1'b1) dones++;
      if (rdy && cmd_valid) begin
        acc_cyc[idx] = cyc;
        idx++;
        if (idx < 4) set_cmd(S_REG, 1'b0, dsts[idx], srcs[idx], 16'h0000, 16'h0000);
        else cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    checks++;
    if (idx !== 4) begin $display("FAIL b2b_accepts got=%0d required 4", idx); errors++; end
    bad_gap = 0;
    for (int i = 1; i < 4; i++) if (acc_cyc[i] - acc_cyc[i-1] != 2) bad_gap++;
    checks++;
    if (bad_gap !== 0) begin
      $display("FAIL b2b_spacing bad_gaps=%0d required 0 (accept every second cycle)", bad_gap); errors++;
    end
    checks++;
    if (dones !== 4) begin $display("FAIL b2b_done_pulses got=%0d required 4", dones); errors++; end
    bad_regs = 0;
    for (int i = 0; i < NR; i++) begin
      rd(i, d);
      if (d !== exp_r[i]) begin
        bad_regs++;
        $display("FAIL b2b_reg%0d got=%h required %h", i, d, exp_r[i]);
      end
    end
    checks++;
    if (bad_regs !== 0) errors++;
  endtask

  initial begin
    test_reset();
    test_single_imm();
    test_pair_test();
    test_pair_mem();
    test_overlap_copy();
    test_reset_mid_mem();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
